// File: rtl/multi_rot_pselect_pkg.sv
// Shared types for the multi-grant rotating priority selector: rotation modes and LFSR step.
// Purely declarative; no latency or flow control of its own.
package multi_rot_pselect_pkg;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        WALKING = 3'd1,
        JUMPING = 3'd2,
        RANDOM  = 3'd3,
        FAIR    = 3'd4
    } ROTATION_TYPE;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Galois right-shift step; a nonzero input can never map to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/multi_rot_pselect_pick.sv
// Finds the first set bit of vec_i at or after base_i, wrapping modulo N.
// Latency: combinational; backpressure: none.
module rot_pick
    import multi_rot_pselect_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec_i,
    input  logic [$clog2(N)-1:0] base_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic [N-1:0]         onehot_o
);

    localparam int LW = $clog2(N);

    // Walk offsets high to low so the smallest offset from base_i wins.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = base_i;
        onehot_o = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (vec_i[base_i + LW'(off)]) begin
                found_o = 1'b1;
                idx_o   = base_i + LW'(off);
            end
        end
        if (found_o) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/multi_rot_pselect.sv
// Grants up to M requesters per cycle in rotating scan order from ptr; ptr advances per rotation mode.
// Latency: grants combinational, ptr updates on the next en=1 edge; backpressure: en=0 masks grants and freezes state.
module multi_rot_pselect
    import multi_rot_pselect_pkg::*;
#(
    parameter int          N         = 8,
    parameter int          M         = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N-1:0]               req,
    input  logic                       en,
    input  ROTATION_TYPE               rotator,
    output logic [N-1:0]               gnt,
    output logic [M-1:0][N-1:0]        gnt_bus,
    output logic [$clog2(M+1)-1:0]     gnt_cnt,
    output logic [$clog2(N)-1:0]       ptr
);

    localparam int LW = $clog2(N);
    localparam int CW = $clog2(M + 1);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("multi_rot_pselect: N must be a power of two >= 2");
    end
    if (M < 1 || M > N) begin : g_bad_m
        $error("multi_rot_pselect: M must satisfy 1 <= M <= N");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("multi_rot_pselect: LFSR_SEED must be nonzero");
    end

    logic [LW-1:0] ptr_q, ptr_d;
    logic          toggle_q, toggle_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic [N-1:0]  avail [M];
    logic [M-1:0]  found;
    logic [LW-1:0] idx [M];
    logic [CW-1:0] cnt;
    logic [LW-1:0] last_idx;

    // Each stage sees the requests left over after all earlier stages' grants.
    for (genvar k = 0; k < M; k++) begin : g_pick
        if (k == 0) begin : g_first
            assign avail[k] = en ? req : '0;
        end else begin : g_next
            assign avail[k] = avail[k-1] & ~gnt_bus[k-1];
        end

        rot_pick #(.N(N)) u_pick (
            .vec_i    (avail[k]),
            .base_i   (ptr_q),
            .found_o  (found[k]),
            .idx_o    (idx[k]),
            .onehot_o (gnt_bus[k])
        );
    end

    always_comb begin
        gnt      = '0;
        cnt      = '0;
        last_idx = ptr_q;
        for (int k = 0; k < M; k++) begin
            gnt = gnt | gnt_bus[k];
            if (found[k]) begin
                cnt      = cnt + CW'(1);
                last_idx = idx[k];
            end
        end
    end

    // Toggle and LFSR step every enabled cycle regardless of mode.
    always_comb begin
        lfsr_d   = lfsr_step(lfsr_q);
        toggle_d = ~toggle_q;
        case (rotator)
            WALKING: ptr_d = ptr_q + LW'(1);
            JUMPING: ptr_d = toggle_q ? ptr_q + LW'(N / 2 + 1) : ptr_q + LW'(N / 2);
            RANDOM:  ptr_d = lfsr_d[LW-1:0];
            FAIR:    ptr_d = (cnt != '0) ? last_idx + LW'(1) : ptr_q;
            default: ptr_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            toggle_q <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else if (en) begin
            ptr_q    <= ptr_d;
            toggle_q <= toggle_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign gnt_cnt = cnt;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_multi_rot_pselect.sv
// Self-checking bench for multi_rot_pselect (N=8, M=2) against a scan-order reference model.
// Directed scenarios per rotation mode, then a randomized soak with async reset pulses.
module tb_multi_rot_pselect;
    import multi_rot_pselect_pkg::*;

    localparam int N = 8;
    localparam int M = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                   clock;
    logic                   reset;
    logic [N-1:0]           req;
    logic                   en;
    ROTATION_TYPE           rotator;
    logic [N-1:0]           gnt;
    logic [M-1:0][N-1:0]    gnt_bus;
    logic [$clog2(M+1)-1:0] gnt_cnt;
    logic [$clog2(N)-1:0]   ptr;

    int checks = 0;
    int errors = 0;

    int          m_ptr;
    bit          m_tog;
    logic [15:0] m_lf;

    multi_rot_pselect #(.N(N), .M(M), .LFSR_SEED(SEED)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .en      (en),
        .rotator (rotator),
        .gnt     (gnt),
        .gnt_bus (gnt_bus),
        .gnt_cnt (gnt_cnt),
        .ptr     (ptr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] ref_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // Scan ptr, ptr+1, ... mod N and take the first M requesters.
    function automatic void ref_grants(input logic [N-1:0] r, input logic e, input int p,
                                       output logic [N-1:0] g, output logic [M-1:0][N-1:0] b,
                                       output int c, output int last);
        g = '0; b = '0; c = 0; last = p;
        if (e) begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = (p + off) % N;
                if (r[i] && c < M) begin
                    g[i] = 1'b1;
                    b[c][i] = 1'b1;
                    c++;
                    last = i;
                end
            end
        end
    endfunction

    function automatic int ref_next(input int mode, input int p, input bit tog,
                                    input logic [15:0] lf, input int c, input int last);
        case (mode)
            1:       return (p + 1) % N;
            2:       return tog ? (p + N / 2 + 1) % N : (p + N / 2) % N;
            3:       return int'(ref_step(lf)) % N;
            4:       return (c > 0) ? (last + 1) % N : p;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_tog = 1'b0;
        m_lf  = SEED;
    endtask

    // Advance one rising edge; called at posedge+1, returns at posedge+1.
    task automatic tick();
        logic [N-1:0] g;
        logic [M-1:0][N-1:0] b;
        int c, l, nxt;
        ref_grants(req, en, m_ptr, g, b, c, l);
        nxt = ref_next(int'(rotator), m_ptr, m_tog, m_lf, c, l);
        @(posedge clock);
        if (en && reset) begin
            m_ptr = nxt;
            m_tog = !m_tog;
            m_lf  = ref_step(m_lf);
        end
        #1;
    endtask

    // Reset pulse entirely between clock edges.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '1; en = 1'b1; rotator = WALKING;
        model_reset();
        #1;
        if (gnt !== 8'h03) begin errors++; $display("FAIL rst_gnt got %h want 03", gnt); end
        checks++;
        if (int'(gnt_cnt) !== 2) begin errors++; $display("FAIL rst_cnt got %0d want 2", gnt_cnt); end
        checks++;
        if (int'(ptr) !== 0) begin errors++; $display("FAIL rst_ptr got %0d want 0", ptr); end
        checks++;
        @(posedge clock); #1;
        if (int'(ptr) !== 0) begin errors++; $display("FAIL rst_hold_ptr got %0d want 0", ptr); end
        checks++;
        reset = 1'b1; en = 1'b0;
        repeat (3) tick();
        if (int'(ptr) !== 0) begin errors++; $display("FAIL noen_ptr got %0d want 0", ptr); end
        checks++;
        if (gnt !== 8'h00 || gnt_cnt !== '0) begin
            errors++; $display("FAIL noen_gnt got %h/%0d want 00/0", gnt, gnt_cnt);
        end
        checks++;
        if (dut.lfsr_q !== SEED) begin errors++; $display("FAIL noen_lfsr got %h want %h", dut.lfsr_q, SEED); end
        checks++;
    endtask

    task automatic test_walking();
        logic [7:0] exp_w [8];
        exp_w = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        rotator = WALKING; req = '1; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (gnt !== exp_w[i] || int'(ptr) !== i) begin
                errors++; $display("FAIL walk_%0d got gnt %h ptr %0d want %h %0d", i, gnt, ptr, exp_w[i], i);
            end
            checks++;
            if (i == 7) begin
                if (gnt_bus[0] !== 8'h80 || gnt_bus[1] !== 8'h01) begin
                    errors++; $display("FAIL walk_bus got %h %h want 80 01", gnt_bus[0], gnt_bus[1]);
                end
                checks++;
            end
            tick();
        end
        if (int'(ptr) !== 0) begin errors++; $display("FAIL walk_wrap got %0d want 0", ptr); end
        checks++;
    endtask

    task automatic test_async_reset();
        rotator = WALKING; en = 1'b1;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        if (int'(ptr) !== 0 || dut.lfsr_q !== SEED) begin
            errors++; $display("FAIL async_rst got ptr %0d lfsr %h want 0 %h", ptr, dut.lfsr_q, SEED);
        end
        checks++;
        model_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_jumping();
        int exp_p [6];
        bit en_p [5];
        exp_p = '{0, 4, 1, 1, 5, 2};
        en_p  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        pulse_reset();
        rotator = JUMPING; req = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            if (int'(ptr) !== exp_p[i]) begin
                errors++; $display("FAIL jump_%0d got ptr %0d want %0d", i, ptr, exp_p[i]);
            end
            checks++;
            if (i < 5) begin
                en = en_p[i];
                tick();
            end
        end
        en = 1'b1;
    endtask

    task automatic test_fair();
        pulse_reset();
        rotator = FAIR; req = 8'hA4; en = 1'b1;
        #1;
        if (gnt !== 8'h24 || int'(gnt_cnt) !== 2 || gnt_bus[0] !== 8'h04 || gnt_bus[1] !== 8'h20) begin
            errors++; $display("FAIL fair_a got %h %0d %h %h want 24 2 04 20", gnt, gnt_cnt, gnt_bus[0], gnt_bus[1]);
        end
        checks++;
        tick();
        if (int'(ptr) !== 6 || gnt !== 8'h84 || gnt_bus[0] !== 8'h80 || gnt_bus[1] !== 8'h04) begin
            errors++; $display("FAIL fair_b got ptr %0d %h %h %h want 6 84 80 04", ptr, gnt, gnt_bus[0], gnt_bus[1]);
        end
        checks++;
        tick();
        if (int'(ptr) !== 3) begin errors++; $display("FAIL fair_c got ptr %0d want 3", ptr); end
        checks++;
        req = '0;
        #1;
        if (gnt !== 8'h00 || gnt_cnt !== '0 || gnt_bus !== '0) begin
            errors++; $display("FAIL fair_idle got %h %0d want 00 0", gnt, gnt_cnt);
        end
        checks++;
        tick();
        if (int'(ptr) !== 3) begin errors++; $display("FAIL fair_hold got ptr %0d want 3", ptr); end
        checks++;
        req = 8'h80;
        #1;
        if (int'(gnt_cnt) !== 1 || gnt_bus[0] !== 8'h80 || gnt_bus[1] !== 8'h00) begin
            errors++; $display("FAIL fair_one got %0d %h %h want 1 80 00", gnt_cnt, gnt_bus[0], gnt_bus[1]);
        end
        checks++;
        tick();
        if (int'(ptr) !== 0) begin errors++; $display("FAIL fair_wrap got ptr %0d want 0", ptr); end
        checks++;
    endtask

    task automatic test_random();
        logic [15:0] exp_lf [3];
        int exp_p [3];
        exp_lf = '{16'hE270, 16'h7138, 16'h389C};
        exp_p  = '{0, 0, 4};
        pulse_reset();
        rotator = RANDOM; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = N'($urandom);
            tick();
            if (dut.lfsr_q !== exp_lf[i] || int'(ptr) !== exp_p[i] || int'(ptr) !== m_ptr) begin
                errors++; $display("FAIL rand_%0d got lfsr %h ptr %0d want %h %0d", i, dut.lfsr_q, ptr, exp_lf[i], exp_p[i]);
            end
            checks++;
        end
    endtask

    task automatic test_undefined();
        en = 1'b1; req = 8'h0F;
        for (int e = 5; e < 8; e++) begin
            rotator = WALKING;
            tick();
            rotator = ROTATION_TYPE'(3'(e));
            tick();
            if (int'(ptr) !== 0) begin errors++; $display("FAIL undef_%0d got ptr %0d want 0", e, ptr); end
            checks++;
        end
    endtask

    task automatic test_soak();
        logic [N-1:0] g;
        logic [M-1:0][N-1:0] b;
        int c, l;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req     = N'($urandom);
            if ($urandom_range(0, 3) == 0) req = '0;
            en      = ($urandom_range(0, 3) != 0);
            rotator = ROTATION_TYPE'(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0) pulse_reset();
            #1;
            ref_grants(req, en, m_ptr, g, b, c, l);
            if (gnt !== g || gnt_bus !== b || int'(gnt_cnt) !== c || int'(ptr) !== m_ptr) begin
                errors++;
                $display("FAIL soak_%0d got gnt %h bus %h cnt %0d ptr %0d want %h %h %0d %0d",
                         cyc, gnt, gnt_bus, gnt_cnt, ptr, g, b, c, m_ptr);
            end
            checks++;
            if ($countones(gnt) > M || (gnt_bus[0] & gnt_bus[1]) !== '0) begin
                errors++; $display("FAIL soak_excl_%0d got gnt %h bus %h want <=%0d bits, disjoint", cyc, gnt, gnt_bus, M);
            end
            checks++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_walking();
        test_async_reset();
        test_jumping();
        test_fair();
        test_random();
        test_undefined();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
